// File: rtl/seq_det_ctrl_if.sv
// Host/config and word-stream bundle for seq_det_ctrl.
// SEQ_DET_ABORT_EN adds the abort signal to the bundle.
interface seq_det_ctrl_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned PW = 5,
    parameter int unsigned CW = 8
);
    logic          cfg_we;
    logic [PW-1:0] cfg_pattern;
    logic          cfg_ovl;
    logic [CW-1:0] cfg_thresh;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          busy;
    logic          det_pulse;
    logic [CW-1:0] match_cnt;
    logic          thresh_hit;
`ifdef SEQ_DET_ABORT_EN
    logic          abort;
`endif

    modport master (
`ifdef SEQ_DET_ABORT_EN
        output abort,
`endif
        output cfg_we, cfg_pattern, cfg_ovl, cfg_thresh, in_valid, in_data,
        input  in_ready, busy, det_pulse, match_cnt, thresh_hit
    );

    modport slave (
`ifdef SEQ_DET_ABORT_EN
        input  abort,
`endif
        input  cfg_we, cfg_pattern, cfg_ovl, cfg_thresh, in_valid, in_data,
        output in_ready, busy, det_pulse, match_cnt, thresh_hit
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Word-to-bit scheduler and pattern-match controller for a serial sequence detector.
// Optional feature: define SEQ_DET_ABORT_EN to enable the mid-word abort input.
module seq_det_ctrl #(
    parameter int unsigned   DW      = 8,
    parameter int unsigned   PW      = 5,
    parameter int unsigned   CW      = 8,
    parameter logic [PW-1:0] DEF_PAT = PW'(5'b10100)
) (
    input  logic           clk,
    input  logic           rst,
    seq_det_ctrl_if.slave  bus
);
    localparam int unsigned BIW = $clog2(DW);
    localparam int unsigned HCW = $clog2(PW + 1);
    localparam logic [BIW-1:0] LAST_IDX = BIW'(DW - 1);
    localparam logic [HCW-1:0] HC_FULL  = HCW'(PW);
    localparam logic [CW-1:0]  CNT_MAX  = '1;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  shreg_q, shreg_d;
    logic [BIW-1:0] bit_idx_q, bit_idx_d;
    logic [PW-1:0]  hist_q, hist_d;
    logic [HCW-1:0] hist_cnt_q, hist_cnt_d;
    logic [PW-1:0]  pat_q, pat_d;
    logic           ovl_q, ovl_d;
    logic [CW-1:0]  thresh_q, thresh_d;
    logic [CW-1:0]  match_cnt_q, match_cnt_d;
    logic           hit_q, hit_d;
    logic           det_q, det_d;

    logic           abort_c;
    logic           in_ready_c;
    logic           last_c;
    logic [PW-1:0]  hist_new_c;
    logic [HCW-1:0] hcnt_new_c;
    logic [CW-1:0]  cnt_inc_c;
    logic           match_c;

`ifdef SEQ_DET_ABORT_EN
    assign abort_c = bus.abort;
`else
    assign abort_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            hist_q      <= '0;
            hist_cnt_q  <= '0;
            pat_q       <= DEF_PAT;
            ovl_q       <= 1'b1;
            thresh_q    <= '0;
            match_cnt_q <= '0;
            hit_q       <= 1'b0;
            det_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            hist_q      <= hist_d;
            hist_cnt_q  <= hist_cnt_d;
            pat_q       <= pat_d;
            ovl_q       <= ovl_d;
            thresh_q    <= thresh_d;
            match_cnt_q <= match_cnt_d;
            hit_q       <= hit_d;
            det_q       <= det_d;
        end
    end

    // Next-state, handshake and match evaluation
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        hist_d      = hist_q;
        hist_cnt_d  = hist_cnt_q;
        pat_d       = pat_q;
        ovl_d       = ovl_q;
        thresh_d    = thresh_q;
        match_cnt_d = match_cnt_q;
        hit_d       = hit_q;
        det_d       = 1'b0;
        in_ready_c  = 1'b0;
        match_c     = 1'b0;

        last_c     = (bit_idx_q == LAST_IDX);
        hist_new_c = PW'({hist_q, shreg_q[DW-1]});
        hcnt_new_c = (hist_cnt_q == HC_FULL) ? HC_FULL : hist_cnt_q + HCW'(1);
        cnt_inc_c  = (match_cnt_q == CNT_MAX) ? match_cnt_q : match_cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                in_ready_c = ~bus.cfg_we;
                if (bus.cfg_we) begin
                    pat_d       = bus.cfg_pattern;
                    ovl_d       = bus.cfg_ovl;
                    thresh_d    = bus.cfg_thresh;
                    hist_d      = '0;
                    hist_cnt_d  = '0;
                    match_cnt_d = '0;
                    hit_d       = 1'b0;
                end else if (bus.in_valid) begin
                    shreg_d   = bus.in_data;
                    bit_idx_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Withhold ready during abort so a word is never accepted and dropped
                in_ready_c = last_c & ~abort_c;
                if (abort_c) begin
                    state_d    = IDLE;
                    hist_d     = '0;
                    hist_cnt_d = '0;
                end else begin
                    hist_d     = hist_new_c;
                    hist_cnt_d = hcnt_new_c;
                    match_c    = (hist_new_c == pat_q) && (hcnt_new_c == HC_FULL);
                    if (match_c) begin
                        det_d       = 1'b1;
                        match_cnt_d = cnt_inc_c;
                        if ((thresh_q != '0) && (cnt_inc_c == thresh_q)) begin
                            hit_d = 1'b1;
                        end
                        if (!ovl_q) begin
                            hist_cnt_d = '0;
                        end
                    end
                    if (last_c) begin
                        if (bus.in_valid) begin
                            shreg_d   = bus.in_data;
                            bit_idx_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d   = shreg_q << 1;
                        bit_idx_d = bit_idx_q + BIW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.busy       = (state_q == SHIFT);
    assign bus.det_pulse  = det_q;
    assign bus.match_cnt  = match_cnt_q;
    assign bus.thresh_hit = hit_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios then random traffic against a bit-queue model.
// Exercises the abort path when SEQ_DET_ABORT_EN is defined.
module tb_seq_det_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 5;
    localparam int unsigned CW = 8;
    localparam logic [PW-1:0] DEF_PAT = 5'b10100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_det_ctrl_if #(.DW(DW), .PW(PW), .CW(CW)) bus ();

    seq_det_ctrl #(.DW(DW), .PW(PW), .CW(CW), .DEF_PAT(DEF_PAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Stream-level reference: bits still to send, and bits seen since last clear
    bit            pend[$];
    bit            hist[$];
    logic [PW-1:0] m_pat;
    bit            m_ovl;
    logic [CW-1:0] m_thr;
    logic [CW-1:0] m_cnt;
    bit            m_hit;
    bit            m_pulse;

    logic [PW-1:0] pat_v = DEF_PAT;
    bit            ovl_v = 1'b1;
    logic [CW-1:0] thr_v = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] hist_val();
        logic [PW-1:0] v = '0;
        foreach (hist[i]) v = {v[PW-2:0], hist[i]};
        return v;
    endfunction

    task automatic push_word(input logic [DW-1:0] d);
        for (int i = DW - 1; i >= 0; i--) pend.push_back(d[i]);
    endtask

    task automatic model_reset();
        pend.delete();
        hist.delete();
        m_pat   = DEF_PAT;
        m_ovl   = 1'b1;
        m_thr   = '0;
        m_cnt   = '0;
        m_hit   = 1'b0;
        m_pulse = 1'b0;
    endtask

    // One clock: drive, check ready, advance model, clock, check registered outputs
    task automatic step(input bit r, input bit we, input bit v, input logic [DW-1:0] d, input bit ab);
        bit exp_ready;
        bit ab_eff;
        bit b;
        bit was_last;
        rst             = r;
        bus.cfg_we      = we;
        bus.cfg_pattern = pat_v;
        bus.cfg_ovl     = ovl_v;
        bus.cfg_thresh  = thr_v;
        bus.in_valid    = v;
        bus.in_data     = d;
`ifdef SEQ_DET_ABORT_EN
        bus.abort       = ab;
        ab_eff          = ab;
`else
        ab_eff          = 1'b0;
`endif
        #1;
        if (pend.size() == 0) exp_ready = !we;
        else                  exp_ready = (pend.size() == 1) && !ab_eff;
        if (!r) chk("in_ready", bus.in_ready, exp_ready);

        m_pulse = 1'b0;
        if (r) begin
            model_reset();
        end else if (pend.size() == 0) begin
            if (we) begin
                m_pat = pat_v; m_ovl = ovl_v; m_thr = thr_v;
                hist.delete(); m_cnt = '0; m_hit = 1'b0;
            end else if (v) begin
                push_word(d);
            end
        end else if (ab_eff) begin
            pend.delete();
            hist.delete();
        end else begin
            b = pend.pop_front();
            was_last = (pend.size() == 0);
            hist.push_back(b);
            if (hist.size() > PW) void'(hist.pop_front());
            if (hist.size() == PW && hist_val() == m_pat) begin
                m_pulse = 1'b1;
                if (m_cnt != '1) m_cnt++;
                if (m_thr != '0 && m_cnt == m_thr) m_hit = 1'b1;
                if (!m_ovl) hist.delete();
            end
            if (was_last && v) push_word(d);
        end

        @(posedge clk);
        #1;
        chk("busy",       bus.busy,       pend.size() != 0);
        chk("det_pulse",  bus.det_pulse,  m_pulse);
        chk("match_cnt",  bus.match_cnt,  m_cnt);
        chk("thresh_hit", bus.thresh_hit, m_hit);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic configure(input logic [PW-1:0] p, input bit o, input logic [CW-1:0] t);
        pat_v = p; ovl_v = o; thr_v = t;
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        model_reset();
        // Reset held two cycles
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle(1);

        // Default pattern 10100 in 8'hA0
        step(1'b0, 1'b0, 1'b1, 8'hA0, 1'b0);
        idle(9);
        chk("t2_match_cnt", bus.match_cnt, 1);

        // Overlapping vs non-overlapping 10101 in 8'hAA
        configure(5'b10101, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
        idle(9);
        chk("t3_ovl_cnt", bus.match_cnt, 2);
        configure(5'b10101, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
        idle(9);
        chk("t3_novl_cnt", bus.match_cnt, 1);

        // Back-to-back words with threshold 2
        configure(DEF_PAT, 1'b1, 8'd2);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 8'hA0, 1'b0);
        idle(10);
        chk("t4_thresh_hit", bus.thresh_hit, 1);
        chk("t4_match_cnt",  bus.match_cnt,  2);

        // cfg_we beats in_valid in IDLE; cfg_we ignored in SHIFT
        pat_v = DEF_PAT; ovl_v = 1'b1; thr_v = 8'd1;
        step(1'b0, 1'b1, 1'b1, 8'hA0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hA0, 1'b0);
        pat_v = 5'b11111; thr_v = '0;
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        idle(9);
        chk("t5_thresh_hit", bus.thresh_hit, 1);

        // Reset mid-word, then default pattern must be back
        configure(5'b00000, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("t6_rst_cnt", bus.match_cnt, 0);
        step(1'b0, 1'b0, 1'b1, 8'hA0, 1'b0);
        idle(9);

`ifdef SEQ_DET_ABORT_EN
        // Abort at bit 3 keeps count and suppresses the pending match
        step(1'b0, 1'b0, 1'b1, 8'hA0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("t6_abort_busy", bus.busy, 0);
        chk("t6_abort_cnt",  bus.match_cnt, 1);
        idle(3);
`endif

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            bit r, we, v, ab;
            logic [DW-1:0] d;
            r  = ($urandom_range(0, 99) == 0);
            we = ($urandom_range(0, 19) == 0);
            v  = ($urandom_range(0, 3) != 0);
            ab = ($urandom_range(0, 39) == 0);
            pat_v = PW'($urandom);
            ovl_v = 1'($urandom);
            thr_v = CW'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) d = {m_pat, 3'($urandom)};
            else                           d = DW'($urandom);
            step(r, we, v, d, ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
